yari_sram_ctrl: RTL and testbench

Memory-side slave for the yari core's unified `mem_*` port, which arbitrates the I-cache and D-cache traffic. It serves each 32-bit word request from an external asynchronous 16-bit SRAM (256K×16) using two half-word bus cycles. Read data returns tagged with the requester's id. Only one request is outstanding at a time, and back-pressure is applied through `mem_waitrequest`.

---
 rtl/yari_mem.sv | 22 ++
 rtl/yari_sram_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_yari_sram_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/yari_mem.sv
// Shared definitions for the yari memory port: requester ids, the SRAM
// controller state encoding and a byte-lane helper.
package yari_mem;

   localparam logic [1:0] ID_NONE = 2'd0;
   localparam logic [1:0] ID_DC   = 2'd1;
   localparam logic [1:0] ID_IC   = 2'd2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      WR_LO = 3'd3,
      WR_HI = 3'd4
   } state_e;

   // Returns the two byte enables that belong to one SRAM half-word.
   function automatic logic [1:0] half_mask(input logic [3:0] mask, input logic hi);
      return hi ? mask[3:2] : mask[1:0];
   endfunction

endpackage

// File: rtl/yari_sram_ctrl.sv
// Memory-side slave for the yari unified mem_* port. Each 32-bit word is
// moved through an asynchronous 16-bit SRAM as two half-word bus cycles,
// with one request in flight and back-pressure via mem_waitrequest.
module yari_sram_ctrl
   import yari_mem::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int SRAM_AW     = 18
) (
   input  logic               clock,
   input  logic               rst,
   input  logic [1:0]         mem_id,
   input  logic [29:0]        mem_address,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [31:0]        mem_writedata,
   input  logic [3:0]         mem_writedatamask,
   output logic               mem_waitrequest,
   output logic [31:0]        mem_readdata,
   output logic [1:0]         mem_readdataid,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_o,
   output logic               sram_dq_oe,
   input  logic [15:0]        sram_dq_i,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   output logic               sram_ub_n,
   output logic               sram_lb_n
);

   localparam int N  = WAIT_CYCLES + 1;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_RD = CW'(N - 1);
   localparam logic [CW-1:0] CNT_WR = CW'(N);

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [SRAM_AW-2:0] addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [3:0]         mask_q, mask_d;
   logic [1:0]         id_q, id_d;
   logic [15:0]        lo_q, lo_d;
   logic [31:0]        readdata_q, readdata_d;
   logic [1:0]         rid_q, rid_d;
   logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
   logic [15:0]        dq_o_q, dq_o_d;
   logic               dq_oe_q, dq_oe_d;
   logic               ce_n_q, ce_n_d;
   logic               oe_n_q, oe_n_d;
   logic               we_n_q, we_n_d;
   logic               ub_n_q, ub_n_d;
   logic               lb_n_q, lb_n_d;
   logic               accept;
   logic               unused_addr_bits;

   // Upper word-address bits fall outside the SRAM and simply alias.
   assign unused_addr_bits = ^mem_address[29:SRAM_AW-1];

   assign accept          = (state_q == IDLE) && (mem_read || mem_write);
   assign mem_waitrequest = (state_q != IDLE);
   assign mem_readdata    = readdata_q;
   assign mem_readdataid  = rid_q;
   assign sram_addr       = sram_addr_q;
   assign sram_dq_o       = dq_o_q;
   assign sram_dq_oe      = dq_oe_q;
   assign sram_ce_n       = ce_n_q;
   assign sram_oe_n       = oe_n_q;
   assign sram_we_n       = we_n_q;
   assign sram_ub_n       = ub_n_q;
   assign sram_lb_n       = lb_n_q;

   // Sequence the half-word accesses, latch the request and assemble read data.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      mask_d     = mask_q;
      id_d       = id_q;
      lo_d       = lo_q;
      readdata_d = readdata_q;
      rid_d      = ID_NONE;

      if (accept) begin
         addr_d  = mem_address[SRAM_AW-2:0];
         wdata_d = mem_writedata;
         mask_d  = mem_writedatamask;
         id_d    = mem_id;
      end

      case (state_q)
         IDLE: begin
            if (mem_write) begin
               if (half_mask(mem_writedatamask, 1'b0) != 2'b00) begin
                  state_d = WR_LO;
                  cnt_d   = CNT_WR;
               end else if (half_mask(mem_writedatamask, 1'b1) != 2'b00) begin
                  state_d = WR_HI;
                  cnt_d   = CNT_WR;
               end
            end else if (mem_read) begin
               state_d = RD_LO;
               cnt_d   = CNT_RD;
            end
         end
         RD_LO: begin
            if (cnt_q == '0) begin
               lo_d    = sram_dq_i;
               state_d = RD_HI;
               cnt_d   = CNT_RD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RD_HI: begin
            if (cnt_q == '0) begin
               readdata_d = {sram_dq_i, lo_q};
               rid_d      = id_q;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WR_LO: begin
            if (cnt_q == '0) begin
               if (half_mask(mask_q, 1'b1) != 2'b00) begin
                  state_d = WR_HI;
                  cnt_d   = CNT_WR;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WR_HI: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Derive next SRAM pin values from the next state so the pins are registered.
   always_comb begin
      sram_addr_d = sram_addr_q;
      dq_o_d      = dq_o_q;
      dq_oe_d     = 1'b0;
      ce_n_d      = 1'b1;
      oe_n_d      = 1'b1;
      we_n_d      = 1'b1;
      ub_n_d      = 1'b1;
      lb_n_d      = 1'b1;

      case (state_d)
         RD_LO, RD_HI: begin
            ce_n_d      = 1'b0;
            oe_n_d      = 1'b0;
            ub_n_d      = 1'b0;
            lb_n_d      = 1'b0;
            sram_addr_d = {addr_d, (state_d == RD_HI)};
         end
         WR_LO: begin
            ce_n_d           = 1'b0;
            dq_oe_d          = 1'b1;
            we_n_d           = (cnt_d == '0);
            {ub_n_d, lb_n_d} = ~half_mask(mask_d, 1'b0);
            sram_addr_d      = {addr_d, 1'b0};
            dq_o_d           = wdata_d[15:0];
         end
         WR_HI: begin
            ce_n_d           = 1'b0;
            dq_oe_d          = 1'b1;
            we_n_d           = (cnt_d == '0);
            {ub_n_d, lb_n_d} = ~half_mask(mask_d, 1'b1);
            sram_addr_d      = {addr_d, 1'b1};
            dq_o_d           = wdata_d[31:16];
         end
         default: begin
         end
      endcase
   end

   // State, request latches and registered SRAM pins; reset aborts any access.
   always_ff @(posedge clock) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mask_q      <= '0;
         id_q        <= ID_NONE;
         lo_q        <= '0;
         readdata_q  <= '0;
         rid_q       <= ID_NONE;
         sram_addr_q <= '0;
         dq_o_q      <= '0;
         dq_oe_q     <= 1'b0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         ub_n_q      <= 1'b1;
         lb_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mask_q      <= mask_d;
         id_q        <= id_d;
         lo_q        <= lo_d;
         readdata_q  <= readdata_d;
         rid_q       <= rid_d;
         sram_addr_q <= sram_addr_d;
         dq_o_q      <= dq_o_d;
         dq_oe_q     <= dq_oe_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         ub_n_q      <= ub_n_d;
         lb_n_q      <= lb_n_d;
      end
   end

endmodule

// File: tb/tb_yari_sram_ctrl.sv
// Directed bench for yari_sram_ctrl with a behavioural 256Kx16 SRAM model.
// Cycle T is the cycle a request is presented with waitrequest low.
module tb_yari_sram_ctrl;
   import yari_mem::*;

   logic        clock = 1'b0;
   logic        rst;
   logic [1:0]  mem_id;
   logic [29:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [3:0]  mem_writedatamask;
   logic        mem_waitrequest;
   logic [31:0] mem_readdata;
   logic [1:0]  mem_readdataid;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_o;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_i;
   logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
   logic [4:0]  ctrl;

   logic [15:0] sram_mem [0:262143];
   logic        model_ready = 1'b0;
   int          we_low_cnt = 0;
   int          ce_low_cnt = 0;
   int          we_base, ce_base;
   int          pass_count = 0;
   int          fail_count = 0;
   int          check_count = 0;

   yari_sram_ctrl #(.WAIT_CYCLES(1), .SRAM_AW(18)) dut (
      .clock             (clock),
      .rst               (rst),
      .mem_id            (mem_id),
      .mem_address       (mem_address),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .mem_writedata     (mem_writedata),
      .mem_writedatamask (mem_writedatamask),
      .mem_waitrequest   (mem_waitrequest),
      .mem_readdata      (mem_readdata),
      .mem_readdataid    (mem_readdataid),
      .sram_addr         (sram_addr),
      .sram_dq_o         (sram_dq_o),
      .sram_dq_oe        (sram_dq_oe),
      .sram_dq_i         (sram_dq_i),
      .sram_ce_n         (sram_ce_n),
      .sram_oe_n         (sram_oe_n),
      .sram_we_n         (sram_we_n),
      .sram_ub_n         (sram_ub_n),
      .sram_lb_n         (sram_lb_n)
   );

   always #5 clock = ~clock;

   // {ce_n, oe_n, we_n, ub_n, lb_n}
   assign ctrl = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n};

   // SRAM drives DQ only when selected, output-enabled and the controller is not driving.
   assign sram_dq_i = (!sram_ce_n && !sram_oe_n && !sram_dq_oe) ? sram_mem[sram_addr] : 16'h0000;

   // SRAM model: preload once, then commit byte writes and count strobes mid-cycle.
   always @(negedge clock) begin
      if (!model_ready) begin
         for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0000;
         sram_mem[18'h00000] = 16'h5555;
         sram_mem[18'h00001] = 16'h6666;
         sram_mem[18'h00020] = 16'h1234;
         sram_mem[18'h00021] = 16'hABCD;
         model_ready = 1'b1;
      end else begin
         if (!sram_we_n) we_low_cnt++;
         if (!sram_ce_n) ce_low_cnt++;
         if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_lb_n) sram_mem[sram_addr][7:0]  = sram_dq_o[7:0];
            if (!sram_ub_n) sram_mem[sram_addr][15:8] = sram_dq_o[15:8];
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      assert (observed === expected) pass_count++;
      else begin
         fail_count++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst = 1'b0;
      mem_id = ID_NONE;
      mem_address = '0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      mem_writedata = '0;
      mem_writedatamask = '0;
      repeat (3) tick();

      // Reset state
      check_output("rst_wait", 32'(mem_waitrequest), 32'd0);
      check_output("rst_rid", 32'(mem_readdataid), 32'd0);
      check_output("rst_rdata", mem_readdata, 32'd0);
      check_output("rst_ctrl", 32'(ctrl), 32'h1F);
      check_output("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
      check_output("rst_addr", 32'(sram_addr), 32'd0);
      check_output("rst_dq_o", 32'(sram_dq_o), 32'd0);
      rst = 1'b1;
      tick();

      // Basic read of address 0x10, id IC
      mem_read = 1'b1; mem_id = ID_IC; mem_address = 30'h10;
      check_output("rd_accept_wait", 32'(mem_waitrequest), 32'd0);
      tick();
      mem_read = 1'b0;
      check_output("rd_t1_wait", 32'(mem_waitrequest), 32'd1);
      check_output("rd_t1_ctrl", 32'(ctrl), 32'h04);
      check_output("rd_t1_addr", 32'(sram_addr), 32'h20);
      check_output("rd_t1_dq_oe", 32'(sram_dq_oe), 32'd0);
      tick();
      check_output("rd_t2_wait", 32'(mem_waitrequest), 32'd1);
      check_output("rd_t2_rid", 32'(mem_readdataid), 32'd0);
      tick();
      check_output("rd_t3_addr", 32'(sram_addr), 32'h21);
      check_output("rd_t3_wait", 32'(mem_waitrequest), 32'd1);
      tick();
      check_output("rd_t4_wait", 32'(mem_waitrequest), 32'd1);
      check_output("rd_t4_rid", 32'(mem_readdataid), 32'd0);
      tick();
      check_output("rd_t5_wait", 32'(mem_waitrequest), 32'd0);
      check_output("rd_t5_rid", 32'(mem_readdataid), 32'd2);
      check_output("rd_t5_rdata", mem_readdata, 32'hABCD1234);
      check_output("rd_t5_ctrl", 32'(ctrl), 32'h1F);
      tick();
      check_output("rd_t6_rid", 32'(mem_readdataid), 32'd0);
      check_output("rd_t6_rdata_hold", mem_readdata, 32'hABCD1234);

      // Full write 0xDEADBEEF to address 5
      mem_write = 1'b1; mem_id = ID_DC; mem_address = 30'd5;
      mem_writedata = 32'hDEADBEEF; mem_writedatamask = 4'hF;
      we_base = we_low_cnt;
      check_output("wr_accept_wait", 32'(mem_waitrequest), 32'd0);
      tick();
      mem_write = 1'b0;
      check_output("wr_t1_wait", 32'(mem_waitrequest), 32'd1);
      check_output("wr_t1_ctrl", 32'(ctrl), 32'h08);
      check_output("wr_t1_addr", 32'(sram_addr), 32'h0A);
      check_output("wr_t1_dq_o", 32'(sram_dq_o), 32'hBEEF);
      check_output("wr_t1_dq_oe", 32'(sram_dq_oe), 32'd1);
      tick();
      check_output("wr_t2_ctrl", 32'(ctrl), 32'h08);
      tick();
      check_output("wr_t3_ctrl_hold", 32'(ctrl), 32'h0C);
      check_output("wr_t3_addr_hold", 32'(sram_addr), 32'h0A);
      check_output("wr_t3_dq_o_hold", 32'(sram_dq_o), 32'hBEEF);
      tick();
      check_output("wr_t4_ctrl", 32'(ctrl), 32'h08);
      check_output("wr_t4_addr", 32'(sram_addr), 32'h0B);
      check_output("wr_t4_dq_o", 32'(sram_dq_o), 32'hDEAD);
      tick();
      tick();
      check_output("wr_t6_ctrl_hold", 32'(ctrl), 32'h0C);
      check_output("wr_t6_wait", 32'(mem_waitrequest), 32'd1);
      tick();
      check_output("wr_t7_wait", 32'(mem_waitrequest), 32'd0);
      check_output("wr_t7_ctrl", 32'(ctrl), 32'h1F);
      check_output("wr_t7_dq_oe", 32'(sram_dq_oe), 32'd0);
      check_output("wr_mem_lo", 32'(sram_mem[18'h0000A]), 32'hBEEF);
      check_output("wr_mem_hi", 32'(sram_mem[18'h0000B]), 32'hDEAD);
      check_output("wr_we_low_cycles", 32'(we_low_cnt - we_base), 32'd4);

      // Read-back of address 5, id DC
      mem_read = 1'b1; mem_id = ID_DC; mem_address = 30'd5;
      tick();
      mem_read = 1'b0;
      repeat (4) tick();
      check_output("rb_rid", 32'(mem_readdataid), 32'd1);
      check_output("rb_rdata", mem_readdata, 32'hDEADBEEF);

      // Single-byte write: byte 2 only -> hi half, lb_n low
      mem_write = 1'b1; mem_address = 30'd5;
      mem_writedata = 32'h00770000; mem_writedatamask = 4'b0100;
      we_base = we_low_cnt;
      tick();
      mem_write = 1'b0;
      check_output("sb_t1_wait", 32'(mem_waitrequest), 32'd1);
      check_output("sb_t1_ctrl", 32'(ctrl), 32'h0A);
      check_output("sb_t1_addr", 32'(sram_addr), 32'h0B);
      check_output("sb_t1_dq_o", 32'(sram_dq_o), 32'h0077);
      tick();
      tick();
      check_output("sb_t3_ctrl_hold", 32'(ctrl), 32'h0E);
      check_output("sb_t3_wait", 32'(mem_waitrequest), 32'd1);
      tick();
      check_output("sb_t4_wait", 32'(mem_waitrequest), 32'd0);
      check_output("sb_mem_hi", 32'(sram_mem[18'h0000B]), 32'hDE77);
      check_output("sb_mem_lo_untouched", 32'(sram_mem[18'h0000A]), 32'hBEEF);
      check_output("sb_we_low_cycles", 32'(we_low_cnt - we_base), 32'd2);

      // Empty mask: accepted, no SRAM activity
      mem_write = 1'b1; mem_address = 30'd6;
      mem_writedata = 32'hFFFFFFFF; mem_writedatamask = 4'h0;
      we_base = we_low_cnt; ce_base = ce_low_cnt;
      check_output("em_accept_wait", 32'(mem_waitrequest), 32'd0);
      tick();
      mem_write = 1'b0;
      check_output("em_t1_wait", 32'(mem_waitrequest), 32'd0);
      check_output("em_t1_ctrl", 32'(ctrl), 32'h1F);
      tick();
      check_output("em_t2_wait", 32'(mem_waitrequest), 32'd0);
      check_output("em_no_ce", 32'(ce_low_cnt - ce_base), 32'd0);
      check_output("em_no_we", 32'(we_low_cnt - we_base), 32'd0);
      check_output("em_mem_untouched", 32'(sram_mem[18'h0000C]), 32'h0000);

      // Back-to-back reads; first one aliases 0x20000 onto SRAM[0]
      mem_read = 1'b1; mem_id = ID_DC; mem_address = 30'h20000;
      tick();
      mem_id = ID_IC; mem_address = 30'd5;
      check_output("bb_t1_wait", 32'(mem_waitrequest), 32'd1);
      check_output("bb_t1_alias_addr", 32'(sram_addr), 32'h0);
      repeat (3) tick();
      check_output("bb_t4_wait", 32'(mem_waitrequest), 32'd1);
      tick();
      check_output("bb_t5_wait", 32'(mem_waitrequest), 32'd0);
      check_output("bb_t5_rid", 32'(mem_readdataid), 32'd1);
      check_output("bb_t5_rdata", mem_readdata, 32'h66665555);
      tick();
      mem_read = 1'b0;
      check_output("bb_t6_rid", 32'(mem_readdataid), 32'd0);
      check_output("bb_t6_wait", 32'(mem_waitrequest), 32'd1);
      check_output("bb_t6_addr", 32'(sram_addr), 32'h0A);
      repeat (4) tick();
      check_output("bb_t10_rid", 32'(mem_readdataid), 32'd2);
      check_output("bb_t10_rdata", mem_readdata, 32'hDE77BEEF);
      tick();
      check_output("bb_t11_rid", 32'(mem_readdataid), 32'd0);

      // Reset during a read
      mem_read = 1'b1; mem_id = ID_IC; mem_address = 30'h10;
      tick();
      mem_read = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      check_output("mr_ctrl", 32'(ctrl), 32'h1F);
      check_output("mr_dq_oe", 32'(sram_dq_oe), 32'd0);
      check_output("mr_wait", 32'(mem_waitrequest), 32'd0);
      check_output("mr_rid", 32'(mem_readdataid), 32'd0);
      check_output("mr_addr", 32'(sram_addr), 32'd0);
      check_output("mr_rdata", mem_readdata, 32'd0);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_output("mr_after_rid", 32'(mem_readdataid), 32'd0);
         check_output("mr_after_ctrl", 32'(ctrl), 32'h1F);
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
